// File: rtl/uart_cmd_pkg.sv
// Shared byte constants and FSM state encoding for the UART command responder.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC  = 8'hA5;
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_E = 8'h45;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_EXEC,
        ST_TX0,
        ST_WAIT0,
        ST_TX1,
        ST_WAIT1
    } state_t;

    // Increment that sticks at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Byte-level handshake between uart_rx/uart_tx and the command responder.
// master = UART side, slave = responder side.
interface uart_cmd_responder_if;

    logic       i_Rx_DV;
    logic [7:0] i_Rx_Byte;
    logic       o_Tx_DV;
    logic [7:0] o_Tx_Byte;
    logic       i_Tx_Active;
    logic       i_Tx_Done;

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done,
        input  o_Tx_DV, o_Tx_Byte
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done,
        output o_Tx_DV, o_Tx_Byte
    );

endinterface

// File: rtl/uart_cmd_regfile.sv
// 2**ADDR_W x 8 register file: synchronous write, combinational read.
// The top slot always reads VERSION and ignores writes, so it needs no storage.
module uart_cmd_regfile
    import uart_cmd_pkg::*;
#(
    parameter int         ADDR_W  = 4,
    parameter logic [7:0] VERSION = 8'h11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata,
    output logic [7:0]        reg0
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] TOP   = ADDR_W'(DEPTH - 1);

    logic [7:0] mem [0:DEPTH-2];

    // Register storage: cleared by reset, written when enabled and not the VERSION slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (we && (waddr != TOP)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (raddr == TOP) ? VERSION : mem[raddr];
    assign reg0  = mem[0];

endmodule

// File: rtl/uart_cmd_responder.sv
// Frame parser / responder between uart_rx and uart_tx.
// Frame: A5, CMD ('W'/'R'), ADDR, [DATA if W], CHK = XOR of CMD,ADDR[,DATA].
// Optional macro UART_CMD_RSP_TIMEOUT_EN adds an inter-byte timeout that
// silently returns a half-received frame to IDLE.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int         ADDR_W       = 4,
    parameter logic [7:0] VERSION      = 8'h11
`ifdef UART_CMD_RSP_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CLKS = 1740
`endif
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    uart_cmd_responder_if.slave   bus,
    output logic                  o_Busy,
    output logic [7:0]            o_Reg0,
    output logic [7:0]            o_Drop_Count
);

    localparam logic [ADDR_W-1:0] TOP = ADDR_W'((2 ** ADDR_W) - 1);

    state_t     state;
    logic [7:0] cmd_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] chk_q;
    logic [7:0] tx_byte;
    logic [7:0] rsp1;
    logic       two_byte;
    logic [7:0] drop_cnt;
    logic [7:0] rdata;

    logic       is_w;
    logic [7:0] data_term;
    logic       exec_err;
    logic       wr_en;

`ifdef UART_CMD_RSP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    logic [TO_W-1:0] to_cnt;
`endif

    assign is_w      = (cmd_q == CMD_W);
    assign data_term = is_w ? data_q : 8'h00;
    assign exec_err  = (chk_q != (cmd_q ^ addr_q ^ data_term))
                     || ((addr_q >> ADDR_W) != 8'h00)
                     || (is_w && (addr_q[ADDR_W-1:0] == TOP));
    assign wr_en     = (state == ST_EXEC) && !exec_err && is_w;

    uart_cmd_regfile #(
        .ADDR_W  (ADDR_W),
        .VERSION (VERSION)
    ) u_regfile (
        .clk   (i_Clock),
        .rst   (i_Reset),
        .we    (wr_en),
        .waddr (addr_q[ADDR_W-1:0]),
        .wdata (data_q),
        .raddr (addr_q[ADDR_W-1:0]),
        .rdata (rdata),
        .reg0  (o_Reg0)
    );

    // Parser / response FSM, drop counter and optional inter-byte timeout.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state    <= ST_IDLE;
            cmd_q    <= 8'h00;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            chk_q    <= 8'h00;
            tx_byte  <= 8'h00;
            rsp1     <= 8'h00;
            two_byte <= 1'b0;
            drop_cnt <= 8'h00;
`ifdef UART_CMD_RSP_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            if (bus.i_Rx_DV && (state inside {ST_EXEC, ST_TX0, ST_WAIT0, ST_TX1, ST_WAIT1})) begin
                drop_cnt <= sat_inc8(drop_cnt);
            end

            case (state)
                ST_IDLE: begin
                    if (bus.i_Rx_DV && (bus.i_Rx_Byte == SYNC)) state <= ST_CMD;
                end
                ST_CMD: begin
                    if (bus.i_Rx_DV) begin
                        if ((bus.i_Rx_Byte == CMD_W) || (bus.i_Rx_Byte == CMD_R)) begin
                            cmd_q <= bus.i_Rx_Byte;
                            state <= ST_ADDR;
                        end else begin
                            // Unknown command: answer at once, rest of frame is not awaited.
                            tx_byte  <= RSP_E;
                            two_byte <= 1'b0;
                            state    <= ST_TX0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.i_Rx_DV) begin
                        addr_q <= bus.i_Rx_Byte;
                        state  <= is_w ? ST_DATA : ST_CHK;
                    end
                end
                ST_DATA: begin
                    if (bus.i_Rx_DV) begin
                        data_q <= bus.i_Rx_Byte;
                        state  <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (bus.i_Rx_DV) begin
                        chk_q <= bus.i_Rx_Byte;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    tx_byte  <= exec_err ? RSP_E : RSP_K;
                    rsp1     <= rdata;
                    two_byte <= !exec_err && !is_w;
                    state    <= ST_TX0;
                end
                ST_TX0: begin
                    if (!bus.i_Tx_Active) state <= ST_WAIT0;
                end
                ST_WAIT0: begin
                    if (bus.i_Tx_Done) begin
                        if (two_byte) begin
                            tx_byte <= rsp1;
                            state   <= ST_TX1;
                        end else begin
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_TX1: begin
                    if (!bus.i_Tx_Active) state <= ST_WAIT1;
                end
                ST_WAIT1: begin
                    if (bus.i_Tx_Done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

`ifdef UART_CMD_RSP_TIMEOUT_EN
            if (state inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK}) begin
                if (bus.i_Rx_DV) begin
                    to_cnt <= '0;
                end else if (to_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
                    to_cnt <= '0;
                    state  <= ST_IDLE;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
`endif
        end
    end

    // Start strobe only while uart_tx is free; byte register holds until done.
    assign bus.o_Tx_DV   = ((state == ST_TX0) || (state == ST_TX1)) && !bus.i_Tx_Active;
    assign bus.o_Tx_Byte = tx_byte;
    assign o_Busy        = (state != ST_IDLE);
    assign o_Drop_Count  = drop_cnt;

endmodule
